// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Commands are registered onto the RAM pins; read data is routed back by a travelling owner tag.
module ram_arbiter #(
  parameter int unsigned WORD     = 1,
  parameter int unsigned SIZE_LOG = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [SIZE_LOG-1:0] a_addr,
  input  logic [WORD-1:0]     a_wdata,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [WORD-1:0]     a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [SIZE_LOG-1:0] b_addr,
  input  logic [WORD-1:0]     b_wdata,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [WORD-1:0]     b_rdata,
  output logic                ram_read,
  output logic                ram_write,
  output logic [SIZE_LOG-1:0] ram_address,
  output logic [WORD-1:0]     ram_data_in,
  input  logic [WORD-1:0]     ram_data_out
);

  // rr_q = 1 means B wins the next contended cycle
  logic                rr_q, rr_d;
  logic                ram_read_q, ram_read_d;
  logic                ram_write_q, ram_write_d;
  logic [SIZE_LOG-1:0] addr_q, addr_d;
  logic [WORD-1:0]     data_q, data_d;
  logic                tag_q, tag_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;

  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    rr_d        = rr_q;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    tag_d       = tag_q;

    if (!reset) begin
      a_gnt = a_req & (~b_req | ~rr_q);
      b_gnt = b_req & (~a_req | rr_q);
    end

    if (a_gnt) begin
      rr_d        = 1'b1;
      ram_read_d  = ~a_we;
      ram_write_d = a_we;
      addr_d      = a_addr;
      data_d      = a_wdata;
      tag_d       = 1'b0;
    end else if (b_gnt) begin
      rr_d        = 1'b0;
      ram_read_d  = ~b_we;
      ram_write_d = b_we;
      addr_d      = b_addr;
      data_d      = b_wdata;
      tag_d       = 1'b1;
    end

    // Second pipeline stage: the RAM returns data the cycle after it samples a read
    a_rvalid_d = ram_read_q & ~tag_q;
    b_rvalid_d = ram_read_q & tag_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q        <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tag_q       <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
    end
  end

  assign ram_read    = ram_read_q;
  assign ram_write   = ram_write_q;
  assign ram_address = addr_q;
  assign ram_data_in = data_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = ram_data_out;
  assign b_rdata     = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a driver predicts grants, RAM commands and read data from a
// plain memory model; an independent monitor compares everything the DUT presents.
module tb_ram_arbiter;
  localparam int W  = 1;
  localparam int SL = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [SL-1:0] a_addr;
  logic [W-1:0]  a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [SL-1:0] b_addr;
  logic [W-1:0]  b_wdata, b_rdata;
  logic          ram_read, ram_write;
  logic [SL-1:0] ram_address;
  logic [W-1:0]  ram_data_in, ram_data_out;

  typedef struct { logic we; logic [SL-1:0] addr; logic [W-1:0] d; } req_t;
  typedef struct { logic we; logic [SL-1:0] addr; logic [W-1:0] d; int cyc; } cmd_t;
  typedef struct { bit port; logic [W-1:0] d; int cyc; } rd_t;

  req_t qa[$], qb[$];
  cmd_t cmdq[$];
  rd_t  rdq[$];
  logic [W-1:0]  ref_mem [2**SL];
  logic [W-1:0]  mem     [2**SL];
  bit            prefer_b = 1'b0;
  logic [SL-1:0] last_addr = '0;
  logic [W-1:0]  last_data = '0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  ram_arbiter #(.WORD(W), .SIZE_LOG(SL)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment RAM: synchronous read, one cycle latency
  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_data_in;
    if (ram_read) ram_data_out <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SL-1:0] rand_addr();
    int v = $urandom_range(0, 8);
    return (v == 8) ? 12'hFFF : SL'(v);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.we   = 1'($urandom_range(0, 1));
    r.addr = rand_addr();
    r.d    = W'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic accept(input bit port, input req_t r);
    cmdq.push_back('{r.we, r.addr, r.d, cyc + 1});
    if (r.we) ref_mem[r.addr] = r.d;
    else rdq.push_back('{port, ref_mem[r.addr], cyc + 2});
  endtask

  // One cycle of stimulus; grants predicted from the round-robin rule
  task automatic step();
    logic ea, eb;
    @(negedge clk);
    a_req = (qa.size() > 0);
    b_req = (qb.size() > 0);
    if (a_req) begin a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].d; end
    else begin a_we = 1'($urandom); a_addr = SL'($urandom); a_wdata = W'($urandom); end
    if (b_req) begin b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].d; end
    else begin b_we = 1'($urandom); b_addr = SL'($urandom); b_wdata = W'($urandom); end
    #1;
    ea = a_req && (!b_req || !prefer_b);
    eb = b_req && (!a_req || prefer_b);
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    if (ea) begin accept(1'b0, qa.pop_front()); prefer_b = 1'b1; end
    else if (eb) begin accept(1'b1, qb.pop_front()); prefer_b = 1'b0; end
  endtask

  task automatic drain(input int extra);
    int guard = 0;
    while ((qa.size() > 0 || qb.size() > 0) && guard < 100) begin
      step();
      guard++;
    end
    chk("drain_timeout", guard >= 100, 0);
    repeat (extra) step();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2;
    reset = 1'b1;
    a_req = 1'b1;
    b_req = 1'b1;
    rdq.delete(); cmdq.delete(); qa.delete(); qb.delete();
    prefer_b  = 1'b0;
    last_addr = '0;
    last_data = '0;
    #1;
    chk("gnt_in_reset", {a_gnt, b_gnt}, 0);
    chk("ram_cmd_in_reset", {ram_read, ram_write}, 0);
    chk("rvalid_in_reset", {a_rvalid, b_rvalid}, 0);
    repeat (cycles) @(negedge clk);
    #2;
    reset = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // Monitor: compares RAM pins and rvalid/rdata every cycle against the queues
  initial begin
    rd_t  e;
    cmd_t c;
    logic exp_a, exp_b;
    forever begin
      @(negedge clk);
      exp_a = 1'b0;
      exp_b = 1'b0;
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        e = rdq.pop_front();
        if (e.port) exp_b = 1'b1;
        else exp_a = 1'b1;
      end
      chk("a_rvalid", a_rvalid, exp_a);
      chk("b_rvalid", b_rvalid, exp_b);
      if (exp_a) chk("a_rdata", a_rdata, e.d);
      if (exp_b) chk("b_rdata", b_rdata, e.d);
      if (cmdq.size() > 0 && cmdq[0].cyc == cyc) begin
        c = cmdq.pop_front();
        chk("ram_write", ram_write, c.we);
        chk("ram_read", ram_read, !c.we);
        chk("ram_address", ram_address, c.addr);
        chk("ram_data_in", ram_data_in, c.d);
        last_addr = c.addr;
        last_data = c.d;
      end else begin
        chk("ram_idle_cmd", {ram_read, ram_write}, 0);
        chk("ram_idle_addr", ram_address, last_addr);
        chk("ram_idle_data", ram_data_in, last_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    #1 reset = 1'b1;
    do_reset(2);

    // Bring every address the stimulus touches to a known value
    for (int i = 0; i < 9; i++) qb.push_back('{1'b1, (i == 8) ? 12'hFFF : SL'(i), 1'b0});
    drain(3);

    // 1: A write then read of 0x005
    do_reset(1);
    qa.push_back('{1'b1, 12'h005, 1'b1});
    qa.push_back('{1'b0, 12'h005, 1'b0});
    drain(3);

    // 2: both ports hold reads; grants alternate starting with A
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      qa.push_back('{1'b0, rand_addr(), 1'b0});
      qb.push_back('{1'b0, rand_addr(), 1'b0});
    end
    drain(3);

    // 3: B write 0xFFF then A read 0xFFF the very next cycle
    qb.push_back('{1'b1, 12'hFFF, 1'b1});
    step();
    qa.push_back('{1'b0, 12'hFFF, 1'b0});
    drain(3);

    // 4: A alone for four cycles, then contention must go to B
    for (int i = 0; i < 4; i++) qa.push_back(rand_req());
    drain(0);
    qa.push_back('{1'b0, 12'h003, 1'b0});
    qb.push_back('{1'b0, 12'h004, 1'b0});
    drain(3);

    // 5: reset one cycle after an A read accept; in-flight read must vanish
    qa.push_back('{1'b0, 12'h005, 1'b0});
    step();
    do_reset(2);
    repeat (3) step();
    qa.push_back('{1'b0, 12'h001, 1'b0});
    qb.push_back('{1'b0, 12'h002, 1'b0});
    drain(3);

    // 6: idle for ten cycles, pointer must be preserved across it
    repeat (10) step();
    qa.push_back('{1'b0, 12'h006, 1'b0});
    qb.push_back('{1'b0, 12'h007, 1'b0});
    drain(3);

    // Randomised traffic on both ports
    for (int i = 0; i < 300; i++) begin
      if (qa.size() == 0 && $urandom_range(0, 2) != 0) qa.push_back(rand_req());
      if (qb.size() == 0 && $urandom_range(0, 2) != 0) qb.push_back(rand_req());
      step();
    end
    drain(4);

    chk("rd_queue_empty", rdq.size(), 0);
    chk("cmd_queue_empty", cmdq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
